// File: rtl/bcd3_count_ctrl.sv
// Three-digit packed-BCD counter sequencer: prescaled increments through a BCD
// incrementor, with start/stop/clear/load control, terminal count and sticky overflow.

module three_BCD_incrementor (
    input  logic [11:0] A,
    input  logic        en,
    output logic [11:0] out,
    output logic        V
);
    logic [3:0] carry;

    always_comb begin
        out      = A;
        carry    = '0;
        carry[0] = en;
        for (int unsigned i = 0; i < 3; i++) begin
            if (carry[i]) begin
                if (A[4*i +: 4] == 4'd9) begin
                    out[4*i +: 4] = 4'd0;
                    carry[i+1]    = 1'b1;
                end else begin
                    out[4*i +: 4] = A[4*i +: 4] + 4'd1;
                end
            end
        end
        V = carry[3];
    end
endmodule

module bcd3_count_ctrl #(
    parameter int unsigned TICK_DIV = 10,
    parameter int unsigned PW       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        load,
    input  logic [11:0] load_val,
    input  logic        limit_en,
    input  logic [11:0] limit,
    output logic [11:0] count,
    output logic        running,
    output logic        done,
    output logic        ovf,
    output logic        load_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [11:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic        ovf_q, ovf_d;
    logic        load_err_q, load_err_d;

    logic        inc_en;
    logic [11:0] inc_out;
    logic        inc_v;

    function automatic logic is_bcd(input logic [11:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    three_BCD_incrementor u_inc (
        .A   (count_q),
        .en  (inc_en),
        .out (inc_out),
        .V   (inc_v)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        presc_d    = presc_q;
        ovf_d      = ovf_q;
        load_err_d = 1'b0;
        inc_en     = 1'b0;

        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
            presc_d = '0;
            state_d = IDLE;
        end else if (load) begin
            // A rejected load freezes the whole cycle, including any pending tick.
            if (is_bcd(load_val)) begin
                count_d = load_val;
                presc_d = '0;
                state_d = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (stop && state_q == RUN) begin
            state_d = IDLE;
        end else if (start && state_q == IDLE) begin
            state_d = RUN;
        end else if (!stop && state_q == RUN) begin
            if (presc_q == TICK_LAST) begin
                inc_en  = 1'b1;
                presc_d = '0;
                count_d = inc_out;
                if (inc_v) ovf_d = 1'b1;
                if (limit_en && is_bcd(limit) && inc_out == limit) begin
                    state_d = DONE;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            presc_q    <= '0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign running  = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign ovf      = ovf_q;
    assign load_err = load_err_q;
endmodule

// File: tb/tb_bcd3_count_ctrl.sv
// Directed-vector bench for bcd3_count_ctrl with TICK_DIV = 4.

module tb_bcd3_count_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, stop, clear, load, limit_en;
    logic [11:0] load_val, limit;
    logic [11:0] count;
    logic        running, done, ovf, load_err;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    bcd3_count_ctrl #(.TICK_DIV(4), .PW(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .limit_en (limit_en),
        .limit    (limit),
        .count    (count),
        .running  (running),
        .done     (done),
        .ovf      (ovf),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [11:0] v);
        load_val = v; load = 1'b1; cyc(1); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; cyc(1); clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        limit_en = 1'b0; load_val = '0; limit = '0;
        cyc(2);
        check("rst_count", count, 12'h000);
        check("rst_running", 12'(running), 12'd0);
        check("rst_done", 12'(done), 12'd0);
        check("rst_ovf", 12'(ovf), 12'd0);
        check("rst_load_err", 12'(load_err), 12'd0);
        reset = 1'b0;

        // basic prescaled counting, enable only on every 4th cycle
        do_start();
        check("run_after_start", 12'(running), 12'd1);
        check("en_off_p0", 12'(dut.inc_en), 12'd0);
        cyc(3);
        check("en_on_p3", 12'(dut.inc_en), 12'd1);
        check("cnt_before_tick", count, 12'h000);
        cyc(1);
        check("cnt_001", count, 12'h001);
        check("en_off_after", 12'(dut.inc_en), 12'd0);
        cyc(4);
        check("cnt_002", count, 12'h002);

        // carry through tens into hundreds
        do_load(12'h098);
        check("load_098", count, 12'h098);
        check("load_idle", 12'(running), 12'd0);
        do_start();
        cyc(4); check("cnt_099", count, 12'h099);
        cyc(4); check("cnt_100", count, 12'h100);

        // wrap and sticky overflow
        do_load(12'h998);
        do_start();
        cyc(4); check("cnt_999", count, 12'h999);
        check("ovf_pre_wrap", 12'(ovf), 12'd0);
        cyc(4); check("cnt_wrap", count, 12'h000);
        check("ovf_set", 12'(ovf), 12'd1);
        check("run_after_wrap", 12'(running), 12'd1);
        do_load(12'h005);
        check("load_005", count, 12'h005);
        check("ovf_kept_load", 12'(ovf), 12'd1);
        do_clear();
        check("ovf_cleared", 12'(ovf), 12'd0);
        check("clear_cnt", count, 12'h000);

        // terminal count
        limit_en = 1'b1; limit = 12'h012;
        do_load(12'h012);
        check("load_eq_limit_nodone", 12'(done), 12'd0);
        do_load(12'h009);
        do_start();
        cyc(4); check("lim_010", count, 12'h010);
        cyc(4); check("lim_011", count, 12'h011);
        cyc(4); check("lim_012", count, 12'h012);
        check("done_set", 12'(done), 12'd1);
        check("done_not_running", 12'(running), 12'd0);
        cyc(21);
        check("done_frozen", count, 12'h012);
        do_start();
        check("start_ignored_done", 12'(done), 12'd1);
        check("start_ignored_run", 12'(running), 12'd0);
        do_clear();
        check("clr_done_cnt", count, 12'h000);
        check("clr_done_flag", 12'(done), 12'd0);
        check("clr_idle", 12'(running), 12'd0);

        // non-BCD limit never matches
        limit = 12'h0A0;
        do_load(12'h099);
        do_start();
        cyc(4); check("badlim_100", count, 12'h100);
        check("badlim_no_done", 12'(done), 12'd0);
        limit_en = 1'b0;

        // rejected load, then load beats start
        do_load(12'h045);
        check("load_045", count, 12'h045);
        do_load(12'h0A3);
        check("load_err_pulse", 12'(load_err), 12'd1);
        check("bad_load_held", count, 12'h045);
        cyc(1);
        check("load_err_drop", 12'(load_err), 12'd0);
        load_val = 12'h100; load = 1'b1; start = 1'b1; cyc(1); load = 1'b0; start = 1'b0;
        check("load_wins_cnt", count, 12'h100);
        check("load_wins_idle", 12'(running), 12'd0);

        // reset mid-run clears everything including ovf
        do_load(12'h999);
        do_start();
        cyc(4); check("ovf_again", 12'(ovf), 12'd1);
        do_load(12'h055);
        do_start();
        cyc(4); check("cnt_056", count, 12'h056);
        cyc(4); check("cnt_057", count, 12'h057);
        cyc(2);
        reset = 1'b1; cyc(1); reset = 1'b0;
        check("midrst_cnt", count, 12'h000);
        check("midrst_run", 12'(running), 12'd0);
        check("midrst_ovf", 12'(ovf), 12'd0);

        // stop on a tick cycle suppresses the increment; start resumes mid-interval
        do_load(12'h020);
        do_start();
        cyc(3);
        stop = 1'b1; cyc(1); stop = 1'b0;
        check("stop_tick_cnt", count, 12'h020);
        check("stop_idle", 12'(running), 12'd0);
        do_start();
        check("resume_cnt", count, 12'h020);
        cyc(1);
        check("resume_tick", count, 12'h021);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd3_count_ctrl.md
Name: bcd3_count_ctrl

Overview:
- Sequencer for the three-digit BCD incrementor (`three_BCD_incrementor`: ports A, en, out, V).
- Holds a 12-bit packed BCD count register (digits [11:8] hundreds, [7:4] tens, [3:0] units).
- Has an internal prescaler. On each prescaler tick it feeds the register through one instantiated incrementor.
- Provides start/stop/clear/load control, terminal-count detection and sticky overflow. Intended as the core of the event counters and stopwatches built on the BCD datapath.

Parameters:
- TICK_DIV, 10, clk cycles per increment while running (must be >= 1; 1 means increment every cycle).
- PW, 4, prescaler counter width; must satisfy 2**PW >= TICK_DIV.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin/resume counting.
- stop  in  1  pause counting.
- clear  in  1  zero count, clear flags, go to IDLE.
- load  in  1  load load_val into count register.
- load_val  in  12  packed BCD value for load.
- limit_en  in  1  enable terminal-count compare.
- limit  in  12  packed BCD terminal value.
- count  out  12  current packed BCD count.
- running  out  1  high in RUN state.
- done  out  1  high in DONE state.
- ovf  out  1  sticky; set when count wraps 999->000.
- load_err  out  1  one-cycle pulse when a load is rejected for a non-BCD digit.

Behaviour:
- Reset (synchronous, highest priority):
  - State = IDLE; count = 12'h000; prescaler = 0.
  - running, done, ovf and load_err all 0.
- States:
  - IDLE (stopped, editable).
  - RUN (counting).
  - DONE (terminal count reached, count frozen).
- Command priority within one cycle: reset > clear > load > stop > start. Only the highest-priority asserted command acts.
- clear (any state): count = 000, ovf = 0, prescaler = 0, next state IDLE.
- load (any state):
  - If every nibble of load_val is <= 9: count = load_val, prescaler = 0, next state IDLE.
  - Otherwise: count and state are unchanged, and load_err pulses high for the next cycle only.
- stop in RUN: next state IDLE. Count and prescaler are held; start resumes mid-interval. stop in IDLE or DONE: no effect.
- start:
  - IDLE -> RUN.
  - Ignored in RUN and DONE; only clear or load leaves DONE.
- Prescaler in RUN: counts 0..TICK_DIV-1. When it equals TICK_DIV-1, a tick occurs and the prescaler returns to 0.
- Tick (1-cycle latency):
  - Incrementor en = 1 and A = count; count <= out on the same edge.
  - The new count is visible the cycle after the tick.
  - The incrementor en is 0 on all non-tick cycles.
- Overflow: if V = 1 on a tick (count was 999), count becomes 000 and ovf is set. ovf stays set until clear or reset; load does not clear ovf.
- Terminal count:
  - If limit_en = 1 and the post-increment value equals limit, next state is DONE and count is frozen at limit.
  - Compare is done on the incrementor output, not on the register.
  - Entering DONE by wrap (limit = 000) also sets ovf.
- limit_en = 0: counting continues indefinitely with wrap.
- Loaded or cleared values equal to limit do not trigger DONE; only a tick does.
- limit containing non-BCD digits never matches (no DONE).
- Simultaneous stop and tick in the same cycle: stop wins and the increment is suppressed.
- running is high only in RUN; done is high only in DONE.

Test Plan:
- TICK_DIV = 4; reset; start held 1 cycle -> running = 1; count = 001 four cycles later, 002 after eight, and so on; the incrementor is enabled exactly every 4th cycle.
- load 12'h098, start, limit_en = 0 -> count steps 098, 099, 100; all digits carry correctly.
- load 12'h998, start -> count 999 then 000; ovf = 1 and stays 1 after a subsequent load of 12'h005; only clear drops it.
- limit_en = 1, limit = 12'h012, load 12'h009, start -> count 010, 011, 012; then done = 1, running = 0, count is held at 012 for more than 20 cycles; start is ignored; clear -> count 000, IDLE.
- load_val = 12'h0A3 while count = 045 -> load_err pulses 1 cycle and count stays 045. Then a cycle with load and start together, load_val 12'h100 -> count = 100, state IDLE (load wins).
- Reset asserted mid-RUN at count 057 -> next cycle count = 000, running = 0, ovf = 0. stop asserted on a tick cycle -> count is not incremented; start resumes the remaining prescaler interval.
